csr_access_arbiter: RTL

- Shares the single CSR-file access port (f3/address/write_data/write_enable/read_data) between two requesters: the core pipeline (port C) and the debug/host bridge (port H).
- Serialises accesses so that the CSR file sees at most one request at a time.
- Holds off accesses while a trap entry or mret is in flight.
- Prevents starvation of H with a bounded-wait counter.

---
 rtl/csr_pkg.sv | 37 +++
 rtl/csr_access_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, funct3 encodings and arbiter enums.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS     = 12'h300;
    localparam logic [11:0] CSR_MIE         = 12'h304;
    localparam logic [11:0] CSR_MTVEC       = 12'h305;
    localparam logic [11:0] CSR_MEPC        = 12'h341;
    localparam logic [11:0] CSR_MCAUSE      = 12'h342;
    localparam logic [11:0] CSR_MIP         = 12'h344;
    localparam logic [11:0] CSR_FLUSH_CACHE = 12'h7C0;
    localparam logic [11:0] CSR_NC_BASE     = 12'h7C1;
    localparam logic [11:0] CSR_NC_LIMIT    = 12'h7C2;

    localparam logic [2:0] CSR_OP_RW  = 3'b001;
    localparam logic [2:0] CSR_OP_RS  = 3'b010;
    localparam logic [2:0] CSR_OP_RC  = 3'b011;
    localparam logic [2:0] CSR_OP_RWI = 3'b101;
    localparam logic [2:0] CSR_OP_RSI = 3'b110;
    localparam logic [2:0] CSR_OP_RCI = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_HOST = 1'b1
    } requester_t;

    // funct3 x00 has no CSR side effect, so it is handled as a pure read.
    function automatic logic f3_writes(input logic [2:0] f3);
        return (f3[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/csr_access_arbiter.sv
// Two-requester (core / host) arbiter in front of the single CSR-file port,
// with trap hold-off and a bounded wait for the host.
module csr_access_arbiter
    import csr_pkg::*;
#(
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        c_req_valid,
    output logic        c_req_ready,
    input  logic [2:0]  c_req_f3,
    input  logic [11:0] c_req_addr,
    input  logic [31:0] c_req_wdata,
    input  logic        c_req_we,
    output logic        c_rsp_valid,
    output logic [31:0] c_rsp_rdata,

    input  logic        h_req_valid,
    output logic        h_req_ready,
    input  logic [2:0]  h_req_f3,
    input  logic [11:0] h_req_addr,
    input  logic [31:0] h_req_wdata,
    input  logic        h_req_we,
    output logic        h_rsp_valid,
    output logic [31:0] h_rsp_rdata,

    input  logic        trap_busy,

    output logic [2:0]  csr_f3,
    output logic [11:0] csr_address,
    output logic [31:0] csr_write_data,
    output logic        csr_write_enable,
    input  logic [31:0] csr_read_data,

    output logic        busy,
    output logic        grant_host
);

    localparam int CNT_W = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(HOST_MAX_WAIT);

    arb_state_t       state_reg, state_next;
    requester_t       owner_reg;
    logic [2:0]       f3_reg;
    logic [11:0]      addr_reg;
    logic [31:0]      wdata_reg;
    logic             we_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [31:0]      rsp_rdata_reg [2];
    logic [1:0]       rsp_valid_vec;

    logic arb_open;
    logic host_wins;
    logic grant_c;
    logic grant_h;
    logic capture;

    // Outputs are forced low while rst_n is held so nothing leaks mid-reset.
    assign arb_open  = rst_n & (state_reg == IDLE) & ~trap_busy;
    assign host_wins = h_req_valid & (~c_req_valid | (wait_cnt_reg == WAIT_MAX));
    assign grant_c   = arb_open & c_req_valid & ~host_wins;
    assign grant_h   = arb_open & host_wins;
    assign capture   = (state_reg == ACCESS) & ~trap_busy;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_c | grant_h) state_next = ACCESS;
            ACCESS:  if (!trap_busy) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= REQ_CORE;
            f3_reg       <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_h) begin
                owner_reg <= REQ_HOST;
                f3_reg    <= h_req_f3;
                addr_reg  <= h_req_addr;
                wdata_reg <= h_req_wdata;
                we_reg    <= h_req_we;
            end else if (grant_c) begin
                owner_reg <= REQ_CORE;
                f3_reg    <= c_req_f3;
                addr_reg  <= c_req_addr;
                wdata_reg <= c_req_wdata;
                we_reg    <= c_req_we;
            end
            // Counts core wins over a waiting host; saturates at the threshold.
            if (grant_h) begin
                wait_cnt_reg <= '0;
            end else if (grant_c && h_req_valid && (wait_cnt_reg != WAIT_MAX)) begin
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rsp_rdata_reg[gi] <= '0;
                end else if (capture && (owner_reg == requester_t'(1'(gi)))) begin
                    rsp_rdata_reg[gi] <= csr_read_data;
                end
            end
            assign rsp_valid_vec[gi] = rst_n & (state_reg == RESP) &
                                       (owner_reg == requester_t'(1'(gi)));
        end
    endgenerate

    assign c_req_ready = grant_c;
    assign h_req_ready = grant_h;
    assign c_rsp_valid = rsp_valid_vec[0];
    assign h_rsp_valid = rsp_valid_vec[1];
    assign c_rsp_rdata = rsp_rdata_reg[0];
    assign h_rsp_rdata = rsp_rdata_reg[1];

    assign csr_f3           = f3_reg;
    assign csr_address      = addr_reg;
    assign csr_write_data   = wdata_reg;
    assign csr_write_enable = rst_n & (state_reg == ACCESS) & we_reg &
                              f3_writes(f3_reg) & ~trap_busy;

    assign busy       = rst_n & (state_reg != IDLE);
    assign grant_host = busy & (owner_reg == REQ_HOST);

endmodule
